adder_share_arbiter: RTL and testbench
======================================

Name: adder_share_arbiter

Overview:
- Shares one registered W-bit adder among NREQ requesters.
- Round-robin grant, valid/ready handshake on each request port, single response channel tagged with the requester index.
- Sits between the pad-level input mux and the output register; it sequences every use of the shared add datapath.

Parameters:
- W, 8, operand and sum width in bits.
- NREQ, 4, number of requesters (≥2).
- IDW, $clog2(NREQ), width of requester index (derived; not overridden).
- CNTW, 16, width of completed-operation counter.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active-high
- req_valid  input  NREQ  bit i: requester i holds a valid operand pair
- req_ready  output  NREQ  bit i: requester i's operands accepted this cycle (one-hot or zero)
- req_a  input  NREQ*W  operand A; slice [i*W +: W] belongs to requester i
- req_b  input  NREQ*W  operand B; same slicing as req_a
- resp_valid  output  1  result available
- resp_ready  input  1  consumer accepts result
- resp_sum  output  W  low W bits of A+B
- resp_carry  output  1  carry out, bit W of A+B
- resp_id  output  IDW  index of requester that owns the result
- busy  output  1  high whenever state ≠ IDLE
- ops_done  output  CNTW  count of completed response handshakes, wraps

Behaviour:
- Reset (async, rst=1): state=IDLE, ptr=0, resp_valid=0, resp_sum=0, resp_carry=0, resp_id=0, ops_done=0, busy=0. req_ready=0 while rst=1. Operand latches cleared to 0.
- FSM has three states: IDLE, ADD, RESP.
- IDLE:
  - If any req_valid is set, the winner is the first set bit searching upward from ptr, wrapping modulo NREQ.
  - req_ready[winner]=1 combinationally in the same cycle. All other req_ready bits stay 0.
  - On that edge: latch req_a/req_b slices and winner id, set ptr ← (winner+1) mod NREQ, go to ADD.
  - With no req_valid: stay in IDLE, ptr unchanged.
- ADD:
  - Compute {carry,sum} = A+B at W+1 bits, unsigned, no saturation.
  - Register into resp_sum/resp_carry, copy id to resp_id, set resp_valid=1, go to RESP.
- RESP:
  - resp_valid=1; resp_sum, resp_carry and resp_id held stable until handshake.
  - On resp_valid && resp_ready: resp_valid←0, ops_done←ops_done+1 (wraps from 2^CNTW−1 to 0), go to IDLE.
  - No new grant is issued in the same cycle as the response handshake.
- Latency and throughput:
  - Grant at edge t gives resp_valid=1 after edge t+1.
  - Earliest handshake is at edge t+2 if resp_ready=1.
  - Best-case throughput is one operation per 3 cycles.
- req_ready is 0 in ADD and RESP regardless of req_valid. Requesters must hold valid and operands until they see ready.
- Once granted, a requester dropping req_valid has no effect; the latched operation completes.
- A requester that deasserts req_valid before grant is simply skipped. Grant decision uses only current-cycle req_valid.
- Simultaneous requests: exactly one grant per IDLE cycle. The requester at ptr has highest priority, ptr−1 (mod NREQ) has lowest. No requester waits more than NREQ−1 other grants.
- resp_sum, resp_carry and resp_id hold their last values after the handshake until the next ADD.
- Reset asserted mid-operation (ADD or RESP) immediately drops resp_valid and busy. The in-flight result is discarded, ops_done is not incremented, and ptr returns to 0.

Test Plan:
1. Reset: drive rst=1 mid-RESP with resp_ready=0 → resp_valid=0 and busy=0 before the next clk edge. After release, the first grant with all req_valid set goes to requester 0.
2. Single request: req_valid=0001, A0=0x12, B0=0x34 → req_ready=0001 in grant cycle, resp_valid 2 edges later with resp_sum=0x46, resp_carry=0, resp_id=0. ops_done=1 after handshake.
3. Overflow: requester 2, A=0xFF, B=0x01 → resp_sum=0x00, resp_carry=1, resp_id=2. Also A=0x80, B=0x80 → resp_sum=0x00, resp_carry=1.
4. Fairness: req_valid=1111 held continuously, resp_ready=1 → resp_id sequence 0,1,2,3,0,1. Each grant spaced 3 cycles apart, one req_ready bit per grant.
5. Rotation: after requester 1 is granted (ptr=2), assert req_valid=1001 → grant goes to 3, then to 0 on the next IDLE.
6. Backpressure: hold resp_ready=0 for 5 cycles with req_valid=1111 → resp_valid, resp_sum and resp_id stay constant, req_ready=0000 throughout, busy=1. When resp_ready=1, one handshake occurs, then the next grant follows one cycle later in IDLE.

Source files
------------

// File: rtl/adder_share_arbiter_if.sv
// Request/response bundle for the shared adder arbiter.
// The arbiter attaches through the slave modport; requesters and consumer use master.
interface adder_share_arbiter_if #(
  parameter int unsigned W    = 8,
  parameter int unsigned NREQ = 4,
  parameter int unsigned CNTW = 16
);
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              resp_valid;
  logic              resp_ready;
  logic [W-1:0]      resp_sum;
  logic              resp_carry;
  logic [IDW-1:0]    resp_id;
  logic              busy;
  logic [CNTW-1:0]   ops_done;

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_sum, resp_carry, resp_id, busy, ops_done
  );

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_sum, resp_carry, resp_id, busy, ops_done
  );
endinterface

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sequencing NREQ requesters onto one registered W-bit adder.
// Grant in IDLE, add in ADD, hold the tagged result in RESP until accepted.
module adder_share_arbiter #(
  parameter int unsigned W    = 8,
  parameter int unsigned NREQ = 4,
  parameter int unsigned CNTW = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  adder_share_arbiter_if.slave  bus
);
  localparam int unsigned IDW = $clog2(NREQ);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]      state_q,      state_d;
  logic [IDW-1:0]  ptr_q,        ptr_d;
  logic [W-1:0]    a_q,          a_d;
  logic [W-1:0]    b_q,          b_d;
  logic [IDW-1:0]  id_q,         id_d;
  logic            resp_valid_q, resp_valid_d;
  logic [W-1:0]    resp_sum_q,   resp_sum_d;
  logic            resp_carry_q, resp_carry_d;
  logic [IDW-1:0]  resp_id_q,    resp_id_d;
  logic [CNTW-1:0] ops_done_q,   ops_done_d;
  logic            busy_q,       busy_d;

  logic            any_c;
  logic [IDW-1:0]  win_c;
  logic [W-1:0]    a_sel_c;
  logic [W-1:0]    b_sel_c;
  logic [NREQ-1:0] grant_c;
  int unsigned     idx_c;

  // First valid requester at or above ptr, wrapping
  always_comb begin
    any_c = 1'b0;
    win_c = '0;
    idx_c = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx_c = 32'(ptr_q) + k;
      if (idx_c >= NREQ) idx_c = idx_c - NREQ;
      if (!any_c && bus.req_valid[IDW'(idx_c)]) begin
        any_c = 1'b1;
        win_c = IDW'(idx_c);
      end
    end
  end

  // Operand mux for the winning requester
  always_comb begin
    a_sel_c = '0;
    b_sel_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_c == IDW'(i)) begin
        a_sel_c = bus.req_a[i*W +: W];
        b_sel_c = bus.req_b[i*W +: W];
      end
    end
  end

  // Ready is combinational so the grant completes in the cycle it is decided
  always_comb begin
    grant_c = '0;
    if (state_q == S_IDLE && any_c && !rst) grant_c = NREQ'(1) << win_c;
    bus.req_ready = grant_c;
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    resp_valid_d = resp_valid_q;
    resp_sum_d   = resp_sum_q;
    resp_carry_d = resp_carry_q;
    resp_id_d    = resp_id_q;
    ops_done_d   = ops_done_q;
    case (state_q)
      S_IDLE: begin
        if (any_c) begin
          a_d     = a_sel_c;
          b_d     = b_sel_c;
          id_d    = win_c;
          ptr_d   = (32'(win_c) == NREQ - 1) ? '0 : IDW'(32'(win_c) + 1);
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        {resp_carry_d, resp_sum_d} = {1'b0, a_q} + {1'b0, b_q};
        resp_id_d    = id_q;
        resp_valid_d = 1'b1;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          ops_done_d   = ops_done_q + CNTW'(1);
          state_d      = S_IDLE;
        end
      end
      default: begin
        resp_valid_d = 1'b0;
        state_d      = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_sum_q   <= '0;
      resp_carry_q <= 1'b0;
      resp_id_q    <= '0;
      ops_done_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      resp_valid_q <= resp_valid_d;
      resp_sum_q   <= resp_sum_d;
      resp_carry_q <= resp_carry_d;
      resp_id_q    <= resp_id_d;
      ops_done_q   <= ops_done_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_sum   = resp_sum_q;
  assign bus.resp_carry = resp_carry_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.ops_done   = ops_done_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Randomized and directed bench for adder_share_arbiter against a transaction-level model.
// A narrow ops counter is used so wrap-around is exercised.
module tb_adder_share_arbiter;
  localparam int unsigned W    = 8;
  localparam int unsigned NREQ = 4;
  localparam int unsigned CNTW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adder_share_arbiter_if #(.W(W), .NREQ(NREQ), .CNTW(CNTW)) bus ();
  adder_share_arbiter #(.W(W), .NREQ(NREQ), .CNTW(CNTW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: stage 0 = free, 1 = operation accepted, 2 = result offered
  int m_stage, m_ptr, m_pres, m_pid, m_sum, m_carry, m_id, m_ops;
  int id_log[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < int'(NREQ); k++) begin
      int i;
      i = (p + k) % int'(NREQ);
      if (v[i] === 1'b1) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_stage = 0; m_ptr = 0; m_pres = 0; m_pid = 0;
    m_sum = 0; m_carry = 0; m_id = 0; m_ops = 0;
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      case (m_stage)
        0: begin
          int w;
          w = pick(bus.req_valid, m_ptr);
          if (w >= 0) begin
            m_pres  = int'(bus.req_a[w*W +: W]) + int'(bus.req_b[w*W +: W]);
            m_pid   = w;
            m_ptr   = (w + 1) % int'(NREQ);
            m_stage = 1;
          end
        end
        1: begin
          m_sum   = m_pres % (1 << W);
          m_carry = m_pres >> W;
          m_id    = m_pid;
          m_stage = 2;
        end
        default: begin
          if (bus.resp_ready) begin
            id_log.push_back(int'(bus.resp_id));
            m_ops   = (m_ops + 1) % (1 << CNTW);
            m_stage = 0;
          end
        end
      endcase
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      logic [NREQ-1:0] exp_rdy;
      int w;
      exp_rdy = '0;
      if (m_stage == 0) begin
        w = pick(bus.req_valid, m_ptr);
        if (w >= 0) exp_rdy[w] = 1'b1;
      end
      check_eq("req_ready",  32'(bus.req_ready),  32'(exp_rdy));
      check_eq("busy",       32'(bus.busy),       32'(m_stage != 0));
      check_eq("resp_valid", 32'(bus.resp_valid), 32'(m_stage == 2));
      check_eq("resp_sum",   32'(bus.resp_sum),   32'(m_sum));
      check_eq("resp_carry", 32'(bus.resp_carry), 32'(m_carry));
      check_eq("resp_id",    32'(bus.resp_id),    32'(m_id));
      check_eq("ops_done",   32'(bus.ops_done),   32'(m_ops));
    end
  end

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_a[r*W +: W] = a;
    bus.req_b[r*W +: W] = b;
  endtask

  initial begin
    model_reset();
    bus.req_valid  = '1;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;
    #2;
    check_eq("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check_eq("rst_busy",       32'(bus.busy),       32'd0);
    check_eq("rst_req_ready",  32'(bus.req_ready),  32'd0);
    check_eq("rst_ops_done",   32'(bus.ops_done),   32'd0);
    check_eq("rst_resp_sum",   32'(bus.resp_sum),   32'd0);
    bus.req_valid = '0;
    run(2);
    rst = 1'b0;

    // Single request
    set_ops(0, 8'h12, 8'h34);
    bus.req_valid  = 4'b0001;
    bus.resp_ready = 1'b1;
    run(1);
    bus.req_valid = '0;
    run(4);
    check_eq("single_sum",   32'(bus.resp_sum),   32'h46);
    check_eq("single_carry", 32'(bus.resp_carry), 32'd0);
    check_eq("single_id",    32'(bus.resp_id),    32'd0);
    check_eq("single_ops",   32'(bus.ops_done),   32'd1);

    // Overflow on requester 2
    set_ops(2, 8'hFF, 8'h01);
    bus.req_valid = 4'b0100;
    run(1);
    bus.req_valid = '0;
    run(4);
    check_eq("ovf1_sum",   32'(bus.resp_sum),   32'h00);
    check_eq("ovf1_carry", 32'(bus.resp_carry), 32'd1);
    check_eq("ovf1_id",    32'(bus.resp_id),    32'd2);
    set_ops(2, 8'h80, 8'h80);
    bus.req_valid = 4'b0100;
    run(1);
    bus.req_valid = '0;
    run(4);
    check_eq("ovf2_sum",   32'(bus.resp_sum),   32'h00);
    check_eq("ovf2_carry", 32'(bus.resp_carry), 32'd1);

    // Rotation: grant 1, then 1001 must go to 3 then 0
    id_log.delete();
    bus.req_valid = 4'b0010;
    run(1);
    bus.req_valid = '0;
    run(4);
    bus.req_valid = 4'b1001;
    run(6);
    bus.req_valid = '0;
    run(4);
    check_eq("rot_count", 32'(id_log.size()), 32'd3);
    if (id_log.size() >= 3) begin
      check_eq("rot_id0", 32'(id_log[0]), 32'd1);
      check_eq("rot_id1", 32'(id_log[1]), 32'd3);
      check_eq("rot_id2", 32'(id_log[2]), 32'd0);
    end

    // Backpressure with all requesters pending
    for (int r = 0; r < int'(NREQ); r++) set_ops(r, W'($urandom), W'($urandom));
    bus.req_valid  = '1;
    bus.resp_ready = 1'b0;
    run(8);
    bus.resp_ready = 1'b1;
    run(6);
    bus.req_valid = '0;
    run(4);

    // Asynchronous reset while a result is being held
    begin
      bit seen;
      seen = 1'b0;
      bus.req_valid  = '1;
      bus.resp_ready = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
        @(negedge clk);
        seen = bus.resp_valid;
      end
      check_eq("midrst_reach_resp", 32'(seen), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check_eq("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check_eq("midrst_busy",       32'(bus.busy),       32'd0);
      check_eq("midrst_req_ready",  32'(bus.req_ready),  32'd0);
      check_eq("midrst_ops_done",   32'(bus.ops_done),   32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
    end

    // Fairness from ptr=0 with everyone requesting
    id_log.delete();
    bus.resp_ready = 1'b1;
    run(18);
    bus.req_valid = '0;
    run(4);
    check_eq("fair_count", 32'(id_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < id_log.size(); i++)
      check_eq($sformatf("fair_id%0d", i), 32'(id_log[i]), 32'(i % 4));

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      for (int r = 0; r < int'(NREQ); r++) set_ops(r, W'($urandom), W'($urandom));
      bus.req_valid  = NREQ'($urandom & $urandom);
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      run(1);
    end
    bus.req_valid  = '0;
    bus.resp_ready = 1'b1;
    run(5);
    check_eq("drain_busy", 32'(bus.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
